crc9_enc_sched: RTL



---
 rtl/crc9_sched_pkg.sv | 15 +
 rtl/crc9_enc_sched_rr_arbiter.sv | 41 ++++
 rtl/crc9_enc_sched.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/crc9_sched_pkg.sv
// rtl/crc9_sched_pkg.sv - shared widths and FSM state type for the CRC9 encoder scheduler
package crc9_sched_pkg;

  localparam int DATA_W = 128;
  localparam int PAR_W  = 9;
  localparam int CODE_W = DATA_W + PAR_W;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FIRE,
    DONE
  } sched_state_t;

endpackage

// File: rtl/crc9_enc_sched_rr_arbiter.sv
// rtl/crc9_enc_sched_rr_arbiter.sv - round-robin arbiter with its own last-grant pointer
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx,
  output logic [W-1:0] ptr
);

  // Search starts one past the last winner so the previous owner goes to the back.
  always_comb begin : search
    logic found;
    int   idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx[W-1:0]]) begin
        found                = 1'b1;
        grant[idx[W-1:0]]    = 1'b1;
        grant_idx            = idx[W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= W'(N - 1);
    end else if (advance) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/crc9_enc_sched.sv
// rtl/crc9_enc_sched.sv - shares one CRC9 encoder among requesters; CRC9_SCHED_TIMEOUT_EN adds a DONE watchdog
module crc9_enc_sched
  import crc9_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TAG_W       = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      enc_enable,
  output logic [DATA_W-1:0]         enc_data,
  input  logic [CODE_W-1:0]         enc_code,
  input  logic                      enc_valid,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CODE_W-1:0]         out_code,
  output logic [TAG_W-1:0]          out_tag,
  output logic                      busy,
  output logic                      err_timeout
);

  sched_state_t         state;
  logic [DATA_W-1:0]    hold_data;
  logic [TAG_W-1:0]     cur_tag;
  logic [NUM_REQ-1:0]   grant;
  logic [TAG_W-1:0]     grant_idx;
  logic [TAG_W-1:0]     arb_ptr_unused;
  logic [DATA_W-1:0]    sel_data;
  logic                 advance;

  assign advance = (state == IDLE) && (|req_valid);

  rr_arbiter #(
    .N (NUM_REQ),
    .W (TAG_W)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req_valid),
    .advance   (advance),
    .grant     (grant),
    .grant_idx (grant_idx),
    .ptr       (arb_ptr_unused)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign req_ready = (state == IDLE) ? grant : '0;
  assign enc_data  = hold_data;
  // The encoder holds its output while enable is low, so DONE can pass it straight through.
  assign out_code  = out_valid ? enc_code : '0;
  assign out_tag   = out_valid ? cur_tag : '0;

`ifdef CRC9_SCHED_TIMEOUT_EN
  localparam int TMO_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;

  assign tmo_hit = (state == DONE) && !out_ready && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt     <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= tmo_hit;
      if (state == FIRE) begin
        tmo_cnt <= '0;
      end else if (out_valid && !out_ready) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign err_timeout        = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      hold_data  <= '0;
      cur_tag    <= '0;
      enc_enable <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            hold_data  <= sel_data;
            cur_tag    <= grant_idx;
            enc_enable <= 1'b1;
            busy       <= 1'b1;
            state      <= LOAD;
          end
        end
        LOAD: begin
          state <= FIRE;
        end
        FIRE: begin
          enc_enable <= 1'b0;
          out_valid  <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
`ifdef CRC9_SCHED_TIMEOUT_EN
          else if (tmo_hit) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
`endif
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // A codeword in DONE without encoder valid means the encoder lost the job mid-flight.
  a_enc_valid_in_done: assert property (@(posedge clk) disable iff (reset)
    (state == DONE) |-> enc_valid);

endmodule
